pipe_stage_buf: RTL

//   Parametrised pipeline-stage register for the CPU datapath (EXE/MEM, ID/EXE, ...).

---
 rtl/pipe_stage_buf.sv | 98 +++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - valid/ready pipeline stage register with flush and back-pressure.
// Optional skid entry enabled by defining PIPE_SKID_EN.
module pipe_stage_buf #(
  parameter int                CTRL_W   = 8,
  parameter int                DATA_W   = 68,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic push;
  logic pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // Ready comes only from the skid flop, so out_ready never reaches in_ready.
  assign in_ready = ~rst & ~skid_valid;
  assign count    = {1'b0, out_valid} + {1'b0, skid_valid};

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_ctrl   <= NOP_CTRL;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= NOP_CTRL;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_ctrl   <= NOP_CTRL;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (pop) begin
        out_ctrl   <= skid_ctrl;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (!out_valid) begin
      if (push) begin
        out_valid <= 1'b1;
        out_ctrl  <= in_ctrl;
        out_data  <= in_data;
      end
    end else if (pop) begin
      if (push) begin
        out_ctrl <= in_ctrl;
        out_data <= in_data;
      end else begin
        out_valid <= 1'b0;
        out_ctrl  <= NOP_CTRL;
      end
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
    end
  end
`else
  assign in_ready = ~rst & (~out_valid | out_ready);
  assign count    = {1'b0, out_valid};

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ctrl  <= NOP_CTRL;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= NOP_CTRL;
    end else if (push) begin
      out_valid <= 1'b1;
      out_ctrl  <= in_ctrl;
      out_data  <= in_data;
    end else if (pop) begin
      out_valid <= 1'b0;
      out_ctrl  <= NOP_CTRL;
    end
  end
`endif

endmodule
